// File: rtl/operand_fetch_pkg.sv
// Shared defaults and helpers for the operand fetch stage and its scoreboard.
package operand_fetch_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_MEM_SIZE    = 8;
    localparam int STALL_CNT_WIDTH = 16;

    localparam logic [STALL_CNT_WIDTH-1:0] STALL_CNT_MAX = '1;

    // Saturating increment for the hazard-stall counter.
    function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(
        input logic [STALL_CNT_WIDTH-1:0] value
    );
        return (value == STALL_CNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard: one bit per tracked register, set when a writer
// is accepted, cleared by either writeback port. Addresses at or beyond
// MEM_SIZE are not tracked and never report a hazard.
module op_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MEM_SIZE   = DEF_MEM_SIZE
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en0,
    input  logic [ADDR_WIDTH-1:0] clr_addr0,
    input  logic                  clr_en1,
    input  logic [ADDR_WIDTH-1:0] clr_addr1,
    input  logic                  src_use0,
    input  logic [ADDR_WIDTH-1:0] src_addr0,
    input  logic                  src_use1,
    input  logic [ADDR_WIDTH-1:0] src_addr1,
    output logic                  hazard
);

    logic [MEM_SIZE-1:0] pending_q;
    logic [MEM_SIZE-1:0] pending_d;
    logic [MEM_SIZE-1:0] set_hit;
    logic [MEM_SIZE-1:0] clr_hit;
    logic [MEM_SIZE-1:0] src0_hit;
    logic [MEM_SIZE-1:0] src1_hit;

    // Per-register address decode for every port.
    generate
        for (genvar gi = 0; gi < MEM_SIZE; gi++) begin : g_decode
            localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(gi);
            assign set_hit[gi]  = set_en && (set_addr == IDX);
            assign clr_hit[gi]  = (clr_en0 && (clr_addr0 == IDX)) ||
                                  (clr_en1 && (clr_addr1 == IDX));
            assign src0_hit[gi] = (src_addr0 == IDX);
            assign src1_hit[gi] = (src_addr1 == IDX);
        end
    endgenerate

    // Hazard ignores bits cleared this cycle (the RAM forwards that write);
    // the new set is applied after the clear so a same-edge set wins.
    always_comb begin
        pending_d = (pending_q & ~clr_hit) | set_hit;
        hazard    = (src_use0 && |(src0_hit & pending_q & ~clr_hit)) ||
                    (src_use1 && |(src1_hit & pending_q & ~clr_hit));
    end

    // Pending-bit register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Two-stage operand fetch: S1 holds an accepted instruction while its
// register reads are in flight, S2 holds the registered operands for the
// downstream consumer. A pending-write scoreboard stalls RAW hazards.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MEM_SIZE   = DEF_MEM_SIZE
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       iValid,
    output logic                       oReady,
    input  logic [ADDR_WIDTH-1:0]      iSrcAddr0,
    input  logic [ADDR_WIDTH-1:0]      iSrcAddr1,
    input  logic                       iSrcUse0,
    input  logic                       iSrcUse1,
    input  logic [ADDR_WIDTH-1:0]      iDestAddr,
    input  logic                       iDestWrite,
    output logic [ADDR_WIDTH-1:0]      oReadAddress0,
    output logic [ADDR_WIDTH-1:0]      oReadAddress1,
    input  logic [DATA_WIDTH-1:0]      iRamData0,
    input  logic [DATA_WIDTH-1:0]      iRamData1,
    input  logic                       iWbEnable0,
    input  logic                       iWbEnable1,
    input  logic [ADDR_WIDTH-1:0]      iWbAddress0,
    input  logic [ADDR_WIDTH-1:0]      iWbAddress1,
    output logic                       oValid,
    input  logic                       iReady,
    output logic [DATA_WIDTH-1:0]      oOperand0,
    output logic [DATA_WIDTH-1:0]      oOperand1,
    output logic [ADDR_WIDTH-1:0]      oDestAddr,
    output logic                       oDestWrite,
    output logic [STALL_CNT_WIDTH-1:0] oStallCount
);

    logic                       s1_valid_q, s1_valid_d;
    logic [ADDR_WIDTH-1:0]      s1_src0_q, s1_src0_d;
    logic [ADDR_WIDTH-1:0]      s1_src1_q, s1_src1_d;
    logic [ADDR_WIDTH-1:0]      s1_dest_q, s1_dest_d;
    logic                       s1_dest_write_q, s1_dest_write_d;

    logic                       o_valid_q, o_valid_d;
    logic [DATA_WIDTH-1:0]      op0_q, op0_d;
    logic [DATA_WIDTH-1:0]      op1_q, op1_d;
    logic [ADDR_WIDTH-1:0]      o_dest_q, o_dest_d;
    logic                       o_dest_write_q, o_dest_write_d;

    logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

    logic hazard;
    logic s1_advance;
    logic s1_free;
    logic accept;

    op_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_SIZE   (MEM_SIZE)
    ) u_scoreboard (
        .Clock     (Clock),
        .Reset     (Reset),
        .set_en    (accept && iDestWrite),
        .set_addr  (iDestAddr),
        .clr_en0   (iWbEnable0),
        .clr_addr0 (iWbAddress0),
        .clr_en1   (iWbEnable1),
        .clr_addr1 (iWbAddress1),
        .src_use0  (iSrcUse0),
        .src_addr0 (iSrcAddr0),
        .src_use1  (iSrcUse1),
        .src_addr1 (iSrcAddr1),
        .hazard    (hazard)
    );

    // Handshake and read-address steering; a held S1 keeps re-reading its own sources.
    always_comb begin
        s1_advance    = s1_valid_q && (!o_valid_q || iReady);
        s1_free       = !s1_valid_q || s1_advance;
        oReady        = !hazard && s1_free;
        accept        = iValid && oReady;
        oReadAddress0 = s1_free ? iSrcAddr0 : s1_src0_q;
        oReadAddress1 = s1_free ? iSrcAddr1 : s1_src1_q;
    end

    // S1 next state: load on accept, empty when it drains into S2.
    always_comb begin
        s1_valid_d      = s1_valid_q;
        s1_src0_d       = s1_src0_q;
        s1_src1_d       = s1_src1_q;
        s1_dest_d       = s1_dest_q;
        s1_dest_write_d = s1_dest_write_q;
        if (accept) begin
            s1_valid_d      = 1'b1;
            s1_src0_d       = iSrcAddr0;
            s1_src1_d       = iSrcAddr1;
            s1_dest_d       = iDestAddr;
            s1_dest_write_d = iDestWrite;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end
    end

    // S2 next state: capture RAM data on advance, otherwise hold until consumed.
    always_comb begin
        o_valid_d      = o_valid_q;
        op0_d          = op0_q;
        op1_d          = op1_q;
        o_dest_d       = o_dest_q;
        o_dest_write_d = o_dest_write_q;
        if (s1_advance) begin
            o_valid_d      = 1'b1;
            op0_d          = iRamData0;
            op1_d          = iRamData1;
            o_dest_d       = s1_dest_q;
            o_dest_write_d = s1_dest_write_q;
        end else if (iReady) begin
            o_valid_d = 1'b0;
        end
    end

    // Stall counter counts offered-but-blocked-by-hazard cycles, saturating.
    always_comb begin
        stall_d = stall_q;
        if (iValid && hazard) begin
            stall_d = sat_inc(stall_q);
        end
    end

    // Pipeline and counter registers; reset discards anything in flight.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1_valid_q      <= 1'b0;
            s1_src0_q       <= '0;
            s1_src1_q       <= '0;
            s1_dest_q       <= '0;
            s1_dest_write_q <= 1'b0;
            o_valid_q       <= 1'b0;
            op0_q           <= '0;
            op1_q           <= '0;
            o_dest_q        <= '0;
            o_dest_write_q  <= 1'b0;
            stall_q         <= '0;
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_src0_q       <= s1_src0_d;
            s1_src1_q       <= s1_src1_d;
            s1_dest_q       <= s1_dest_d;
            s1_dest_write_q <= s1_dest_write_d;
            o_valid_q       <= o_valid_d;
            op0_q           <= op0_d;
            op1_q           <= op1_d;
            o_dest_q        <= o_dest_d;
            o_dest_write_q  <= o_dest_write_d;
            stall_q         <= stall_d;
        end
    end

    assign oValid      = o_valid_q;
    assign oOperand0   = op0_q;
    assign oOperand1   = op1_q;
    assign oDestAddr   = o_dest_q;
    assign oDestWrite  = o_dest_write_q;
    assign oStallCount = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a register-file RAM model, a driver that keeps an
// abstract model (register values, outstanding-write set, occupancy count)
// and queues expected results, and a monitor that checks every delivery.
module tb_operand_fetch;

    typedef struct {
        logic        use0;
        logic [15:0] op0;
        logic        use1;
        logic [15:0] op1;
        logic [7:0]  dest;
        logic        dw;
    } exp_t;

    logic        clk = 1'b0;
    logic        Reset;
    logic        iValid;
    logic        oReady;
    logic [7:0]  iSrcAddr0, iSrcAddr1;
    logic        iSrcUse0, iSrcUse1;
    logic [7:0]  iDestAddr;
    logic        iDestWrite;
    logic [7:0]  oReadAddress0, oReadAddress1;
    logic [15:0] iRamData0, iRamData1;
    logic        iWbEnable0, iWbEnable1;
    logic [7:0]  iWbAddress0, iWbAddress1;
    logic        oValid;
    logic        iReady;
    logic [15:0] oOperand0, oOperand1;
    logic [7:0]  oDestAddr;
    logic        oDestWrite;
    logic [15:0] oStallCount;
    logic [15:0] wb_data0, wb_data1;

    logic [15:0] ram [0:255];
    logic [15:0] regs [0:255];
    logic [7:0]  pend_m;
    int          stall_m;
    exp_t        exp_q[$];
    logic [7:0]  wb_q[$];
    int          n_tests;
    int          n_fail;
    int          n_out;

    always #5 clk = ~clk;

    operand_fetch dut (
        .Clock         (clk),
        .Reset         (Reset),
        .iValid        (iValid),
        .oReady        (oReady),
        .iSrcAddr0     (iSrcAddr0),
        .iSrcAddr1     (iSrcAddr1),
        .iSrcUse0      (iSrcUse0),
        .iSrcUse1      (iSrcUse1),
        .iDestAddr     (iDestAddr),
        .iDestWrite    (iDestWrite),
        .oReadAddress0 (oReadAddress0),
        .oReadAddress1 (oReadAddress1),
        .iRamData0     (iRamData0),
        .iRamData1     (iRamData1),
        .iWbEnable0    (iWbEnable0),
        .iWbEnable1    (iWbEnable1),
        .iWbAddress0   (iWbAddress0),
        .iWbAddress1   (iWbAddress1),
        .oValid        (oValid),
        .iReady        (iReady),
        .oOperand0     (oOperand0),
        .oOperand1     (oOperand1),
        .oDestAddr     (oDestAddr),
        .oDestWrite    (oDestWrite),
        .oStallCount   (oStallCount)
    );

    // Dual-port register RAM: registered read with same-cycle write forwarding.
    always @(posedge clk) begin
        if (iWbEnable1 && iWbAddress1 == oReadAddress0)      iRamData0 <= wb_data1;
        else if (iWbEnable0 && iWbAddress0 == oReadAddress0) iRamData0 <= wb_data0;
        else                                                 iRamData0 <= ram[oReadAddress0];
        if (iWbEnable1 && iWbAddress1 == oReadAddress1)      iRamData1 <= wb_data1;
        else if (iWbEnable0 && iWbAddress0 == oReadAddress1) iRamData1 <= wb_data0;
        else                                                 iRamData1 <= ram[oReadAddress1];
        if (iWbEnable0) ram[iWbAddress0] <= wb_data0;
        if (iWbEnable1) ram[iWbAddress1] <= wb_data1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        iValid = 1'b0; iSrcUse0 = 1'b0; iSrcUse1 = 1'b0;
        iDestWrite = 1'b0; iWbEnable0 = 1'b0; iWbEnable1 = 1'b0;
    endtask

    // Called with inputs driven just after a rising edge: predicts the
    // handshake from the model, updates the model, then crosses the edge.
    task automatic cycle();
        logic [7:0] clr;
        logic       hz;
        logic       rdy;
        exp_t       e;
        #1;
        clr = '0;
        if (iWbEnable0 && iWbAddress0 < 8) clr[iWbAddress0[2:0]] = 1'b1;
        if (iWbEnable1 && iWbAddress1 < 8) clr[iWbAddress1[2:0]] = 1'b1;
        hz = (iSrcUse0 && iSrcAddr0 < 8 && pend_m[iSrcAddr0[2:0]] && !clr[iSrcAddr0[2:0]]) ||
             (iSrcUse1 && iSrcAddr1 < 8 && pend_m[iSrcAddr1[2:0]] && !clr[iSrcAddr1[2:0]]);
        rdy = !hz && (exp_q.size() < 2 || iReady);
        if (!Reset) begin
            check("ready", oReady, rdy);
            if (iValid && hz && stall_m < 65535) stall_m++;
        end
        if (iWbEnable0) regs[iWbAddress0] = wb_data0;
        if (iWbEnable1) regs[iWbAddress1] = wb_data1;
        pend_m = pend_m & ~clr;
        if (!Reset && iValid && rdy) begin
            e.use0 = iSrcUse0; e.op0 = regs[iSrcAddr0];
            e.use1 = iSrcUse1; e.op1 = regs[iSrcAddr1];
            e.dest = iDestAddr; e.dw = iDestWrite;
            exp_q.push_back(e);
            if (iDestWrite && iDestAddr < 8) pend_m[iDestAddr[2:0]] = 1'b1;
        end
        if (Reset) begin
            pend_m = '0;
            stall_m = 0;
            exp_q.delete();
            wb_q.delete();
        end
        @(posedge clk);
        #1;
        check("stall_count", oStallCount, stall_m[15:0]);
    endtask

    // Monitor: compares each delivered result against the queued expectation
    // and checks that a stalled output stays stable.
    logic        hold;
    logic [15:0] h_op0, h_op1;
    logic [7:0]  h_dest;
    logic        h_dw;
    exp_t        mon_e;
    initial begin
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (Reset) begin
                hold = 1'b0;
            end else begin
                if (hold && oValid) begin
                    check("hold_op0", oOperand0, h_op0);
                    check("hold_op1", oOperand1, h_op1);
                    check("hold_dest", {oDestWrite, oDestAddr}, {h_dw, h_dest});
                end
                if (oValid && iReady) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_output: got oValid=1 dest=%0d required no output", oDestAddr);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.use0) check("operand0", oOperand0, mon_e.op0);
                        if (mon_e.use1) check("operand1", oOperand1, mon_e.op1);
                        check("dest_addr", oDestAddr, mon_e.dest);
                        check("dest_write", oDestWrite, mon_e.dw);
                        n_out++;
                        $display("[TB] out %0d dest=%0d write=%0b op0=%h op1=%h",
                                 n_out, oDestAddr, oDestWrite, oOperand0, oOperand1);
                        if (mon_e.dw) wb_q.push_back(mon_e.dest);
                    end
                end
                hold   = oValid && !iReady;
                h_op0  = oOperand0;
                h_op1  = oOperand1;
                h_dest = oDestAddr;
                h_dw   = oDestWrite;
            end
        end
    end

    initial begin
        n_tests = 0; n_fail = 0; n_out = 0;
        pend_m = '0; stall_m = 0;
        for (int i = 0; i < 256; i++) regs[i] = '0;
        idle_inputs();
        iSrcAddr0 = 8'd3; iSrcAddr1 = 8'd4; iDestAddr = '0;
        iWbAddress0 = '0; iWbAddress1 = '0; wb_data0 = '0; wb_data1 = '0;
        iReady = 1'b1;
        Reset = 1'b1;
        @(posedge clk); #1;

        // Reset state
        cycle(); cycle();
        check("rst_ovalid", oValid, 1'b0);
        check("rst_stall", oStallCount, 16'h0);
        check("rst_dest_write", oDestWrite, 1'b0);
        check("rst_operand0", oOperand0, 16'h0);
        check("rst_raddr0", oReadAddress0, iSrcAddr0);
        Reset = 1'b0;

        // Preload all tracked registers through the writeback ports
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            iWbEnable0 = 1'b1; iWbAddress0 = 8'(2 * i);
            iWbEnable1 = 1'b1; iWbAddress1 = 8'(2 * i + 1);
            wb_data0 = 16'($urandom); wb_data1 = 16'($urandom);
            if (i == 1) wb_data1 = 16'h0011;
            if (i == 2) wb_data0 = 16'h0022;
            cycle();
        end

        // Basic fetch and one-edge latency
        idle_inputs();
        iValid = 1'b1; iSrcAddr0 = 8'd3; iSrcAddr1 = 8'd4; iSrcUse0 = 1'b1; iSrcUse1 = 1'b1;
        cycle();
        check("lat_before", oValid, 1'b0);
        idle_inputs();
        cycle();
        check("lat_after", oValid, 1'b1);
        check("fetch_op0", oOperand0, 16'h0011);
        check("fetch_op1", oOperand1, 16'h0022);
        cycle();

        // RAW hazard stall, released by a same-cycle writeback
        idle_inputs();
        iValid = 1'b1; iDestAddr = 8'd5; iDestWrite = 1'b1;
        cycle();
        idle_inputs();
        iValid = 1'b1; iSrcAddr0 = 8'd5; iSrcUse0 = 1'b1;
        begin
            int s0;
            s0 = stall_m;
            repeat (3) cycle();
            check("stall_delta", oStallCount, 16'(s0 + 3));
        end
        check("ready_hazard", oReady, 1'b0);
        iWbEnable0 = 1'b1; iWbAddress0 = 8'd5; wb_data0 = 16'h00AB;
        #1 check("ready_on_wb", oReady, 1'b1);
        cycle();
        idle_inputs();
        cycle();
        check("wb_fwd_valid", oValid, 1'b1);
        check("wb_fwd_op0", oOperand0, 16'h00AB);
        cycle();

        // Downstream backpressure with two instructions in flight
        iReady = 1'b0;
        idle_inputs();
        iValid = 1'b1; iSrcAddr0 = 8'd1; iSrcAddr1 = 8'd2; iSrcUse0 = 1'b1; iSrcUse1 = 1'b1;
        cycle();
        iSrcAddr0 = 8'd3; iSrcAddr1 = 8'd6;
        cycle();
        iSrcAddr0 = 8'd0; iSrcAddr1 = 8'd7;
        #1;
        check("held_raddr0", oReadAddress0, 8'd3);
        check("held_raddr1", oReadAddress1, 8'd6);
        check("ready_full", oReady, 1'b0);
        repeat (3) cycle();
        check("held_raddr0_late", oReadAddress0, 8'd3);
        idle_inputs();
        iReady = 1'b1;
        repeat (3) cycle();
        check("backpressure_drained", exp_q.size(), 0);

        // Same-edge set and clear of one register: set wins
        idle_inputs();
        iValid = 1'b1; iDestAddr = 8'd7; iDestWrite = 1'b1;
        iWbEnable1 = 1'b1; iWbAddress1 = 8'd7; wb_data1 = 16'h0777;
        cycle();
        idle_inputs();
        iValid = 1'b1; iSrcAddr0 = 8'd7; iSrcUse0 = 1'b1;
        #1 check("set_wins_ready", oReady, 1'b0);
        cycle(); cycle();
        iWbEnable0 = 1'b1; iWbAddress0 = 8'd7; wb_data0 = 16'h1234;
        cycle();
        idle_inputs();
        repeat (3) cycle();

        // Reset with both stages occupied and a write pending
        iReady = 1'b0;
        idle_inputs();
        iValid = 1'b1; iSrcAddr0 = 8'd1; iSrcAddr1 = 8'd2; iDestAddr = 8'd6; iDestWrite = 1'b1;
        cycle();
        idle_inputs();
        iValid = 1'b1; iSrcAddr0 = 8'd3; iSrcAddr1 = 8'd4; iDestAddr = 8'd0;
        cycle();
        idle_inputs();
        iValid = 1'b1; iSrcAddr0 = 8'd6; iSrcUse0 = 1'b1;
        cycle();
        check("pre_rst_ovalid", oValid, 1'b1);
        Reset = 1'b1;
        idle_inputs();
        cycle();
        check("mid_rst_ovalid", oValid, 1'b0);
        check("mid_rst_stall", oStallCount, 16'h0);
        Reset = 1'b0;
        iSrcAddr0 = 8'd6; iSrcUse0 = 1'b1;
        #1;
        check("mid_rst_pending", oReady, 1'b1);
        check("mid_rst_raddr0", oReadAddress0, 8'd6);
        idle_inputs();
        iReady = 1'b1;
        repeat (4) cycle();

        // Randomized traffic
        wb_q.delete();
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            iReady = ($urandom_range(0, 3) != 0);
            if (wb_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                iWbEnable0 = 1'b1; iWbAddress0 = wb_q.pop_front(); wb_data0 = 16'($urandom);
            end
            if (wb_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                iWbEnable1 = 1'b1; iWbAddress1 = wb_q.pop_front(); wb_data1 = 16'($urandom);
            end
            iSrcAddr0 = 8'($urandom_range(0, 7));
            iSrcAddr1 = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 7) begin
                iValid = 1'b1;
                iSrcUse0 = 1'($urandom_range(0, 1));
                iSrcUse1 = 1'($urandom_range(0, 1));
                iDestAddr = 8'($urandom_range(0, 7));
                iDestWrite = ($urandom_range(0, 1) == 1) && !pend_m[iDestAddr[2:0]];
            end
            cycle();
        end
        for (int c = 0; c < 30; c++) begin
            idle_inputs();
            iReady = 1'b1;
            if (wb_q.size() > 0) begin
                iWbEnable0 = 1'b1; iWbAddress0 = wb_q.pop_front(); wb_data0 = 16'($urandom);
            end
            if (wb_q.size() > 0) begin
                iWbEnable1 = 1'b1; iWbAddress1 = wb_q.pop_front(); wb_data1 = 16'($urandom);
            end
            cycle();
        end
        check("random_drained", exp_q.size(), 0);

        // Long hazard: stall counter saturates
        idle_inputs();
        iValid = 1'b1; iDestAddr = 8'd2; iDestWrite = 1'b1;
        cycle();
        idle_inputs();
        iValid = 1'b1; iSrcAddr0 = 8'd2; iSrcUse0 = 1'b1;
        repeat (70000) cycle();
        check("stall_saturated", oStallCount, 16'hFFFF);
        iWbEnable0 = 1'b1; iWbAddress0 = 8'd2; wb_data0 = 16'h5A5A;
        cycle();
        idle_inputs();
        repeat (4) cycle();
        check("final_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
